// File: rtl/systolic_skew_feeder.sv
// Skew feeder for an NxN output-stationary systolic MAC array.
// Takes one column of A and one row of B per accepted beat and presents them
// on the west/north edges with lane i delayed by i extra cycles. It also
// sequences the accumulator clear before a product and a done pulse after it.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [N*DATA_WIDTH-1:0] a_col_i,
    input  logic [N*DATA_WIDTH-1:0] b_row_i,
    output logic [N*DATA_WIDTH-1:0] a_o,
    output logic [N*DATA_WIDTH-1:0] b_o,
    output logic                    clr_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int DW = DATA_WIDTH;
    localparam int BW = $clog2(N + 1);
    localparam int FW = $clog2(2 * N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state_reg;
    logic [BW-1:0]   beat_cnt_reg;
    logic [FW-1:0]   flush_cnt_reg;
    logic            accept;

    // A beat is taken only while the feeder itself advertises ready (FEED only).
    assign accept = in_valid_i & in_ready_o;

    // Product sequencer; every control output is a register so the array sees clean edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            in_ready_o    <= 1'b0;
            clr_o         <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            clr_o  <= 1'b0;
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg <= CLEAR;
                        clr_o     <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_reg    <= FEED;
                    in_ready_o   <= 1'b1;
                    beat_cnt_reg <= '0;
                end
                FEED: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if (beat_cnt_reg == BW'(N - 1)) begin
                            state_reg     <= FLUSH;
                            in_ready_o    <= 1'b0;
                            flush_cnt_reg <= FW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == FW'(2 * N)) begin
                        // done_o was raised for this final flush cycle; drop back to idle.
                        state_reg     <= IDLE;
                        busy_o        <= 1'b0;
                        flush_cnt_reg <= '0;
                        beat_cnt_reg  <= '0;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                        // Raise done so it is visible in the cycle where the count reads 2N.
                        if (flush_cnt_reg == FW'(2 * N - 1)) begin
                            done_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    in_ready_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

    // One shift chain per lane, i+1 deep, for both the A and B edges.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DW-1:0] a_sr_reg [0:gi];
            logic [DW-1:0] b_sr_reg [0:gi];

            // Stage 0 captures the lane input on an accept and a zero otherwise, so
            // bubbles and idle cycles push zeros through; the chain never stalls.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s <= gi; s++) begin
                        a_sr_reg[s] <= '0;
                        b_sr_reg[s] <= '0;
                    end
                end else begin
                    a_sr_reg[0] <= accept ? a_col_i[gi*DW +: DW] : '0;
                    b_sr_reg[0] <= accept ? b_row_i[gi*DW +: DW] : '0;
                    for (int s = 1; s <= gi; s++) begin
                        a_sr_reg[s] <= a_sr_reg[s-1];
                        b_sr_reg[s] <= b_sr_reg[s-1];
                    end
                end
            end

            assign a_o[gi*DW +: DW] = a_sr_reg[gi];
            assign b_o[gi*DW +: DW] = b_sr_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a table of products (A, B, bubble pattern,
// expected C) driven through the feeder, with a behavioural output-stationary
// PE array hung off a_o/b_o/clr_o, plus hand-written reset sequences.
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int HIST = 4096;

    logic              clk;
    logic              reset_n;
    logic              start_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [N*DW-1:0]   a_col_i;
    logic [N*DW-1:0]   b_row_i;
    logic [N*DW-1:0]   a_o;
    logic [N*DW-1:0]   b_o;
    logic              clr_o;
    logic              busy_o;
    logic              done_o;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_col_i    (a_col_i),
        .b_row_i    (b_row_i),
        .a_o        (a_o),
        .b_o        (b_o),
        .clr_o      (clr_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int clr_seen  = 0;
    int done_seen = 0;
    bit exp_accept = 0;

    bit [N*DW-1:0] hist_a [HIST];
    bit [N*DW-1:0] hist_b [HIST];

    // Behavioural PE array: a flows east, b flows south, one register per hop.
    bit [DW-1:0] ar  [N][N];
    bit [DW-1:0] br  [N][N];
    bit [31:0]   acc [N][N];
    bit [DW-1:0] pa, pb;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pa = (j == 0) ? a_o[i*DW +: DW] : ar[i][j-1];
                pb = (i == 0) ? b_o[j*DW +: DW] : br[i-1][j];
                ar[i][j] <= pa;
                br[i][j] <= pb;
                if (clr_o === 1'b1) acc[i][j] <= 32'd0;
                else                acc[i][j] <= acc[i][j] + 32'(pa) * 32'(pb);
            end
        end
    end

    typedef struct {
        logic [N*N-1:0][DW-1:0] a;   // A[i][k] at i*N+k
        logic [N*N-1:0][DW-1:0] b;   // B[k][j] at k*N+j
        int                     bub_after;
        int                     bub_len;
        bit                     glitch;
        logic [N*N-1:0][31:0]   c;   // expected C[i][j] at i*N+j
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: log what the bench expects to be accepted, step, then check lanes.
    task automatic tick();
        if (cyc < HIST) begin
            hist_a[cyc] = exp_accept ? a_col_i : '0;
            hist_b[cyc] = exp_accept ? b_row_i : '0;
        end
        exp_accept = 0;
        @(posedge clk);
        #1;
        cyc++;
        if (clr_o === 1'b1) clr_seen++;
        if (done_o === 1'b1) done_seen++;
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] ea, eb;
            int t;
            t  = cyc - 1 - i;
            ea = (t >= 0 && t < HIST) ? hist_a[t][i*DW +: DW] : '0;
            eb = (t >= 0 && t < HIST) ? hist_b[t][i*DW +: DW] : '0;
            check($sformatf("a_lane%0d", i), 64'(a_o[i*DW +: DW]), 64'(ea));
            check($sformatf("b_lane%0d", i), 64'(b_o[i*DW +: DW]), 64'(eb));
        end
    endtask

    task automatic clear_hist();
        for (int t = 0; t < HIST; t++) begin
            hist_a[t] = '0;
            hist_b[t] = '0;
        end
    endtask

    task automatic load_beat(input int v, input int k);
        for (int i = 0; i < N; i++) begin
            a_col_i[i*DW +: DW] = vecs[v].a[i*N+k];
            b_row_i[i*DW +: DW] = vecs[v].b[k*N+i];
        end
    endtask

    // Full product from the table: start, clear, beats (with bubbles), flush, done.
    task automatic run_product(input int v);
        clr_seen  = 0;
        done_seen = 0;
        start_i    = 1'b1;
        in_valid_i = 1'b1;               // ignored in IDLE and CLEAR
        a_col_i    = {N{8'hAB}};
        b_row_i    = {N{8'hCD}};
        tick();
        start_i = 1'b0;
        check("clear_clr", 64'(clr_o), 64'(1));
        check("clear_ready", 64'(in_ready_o), 64'(0));
        check("clear_busy", 64'(busy_o), 64'(1));
        tick();
        in_valid_i = 1'b0;
        check("feed_ready", 64'(in_ready_o), 64'(1));
        check("feed_clr", 64'(clr_o), 64'(0));
        for (int k = 0; k < N; k++) begin
            if (k == vecs[v].bub_after + 1) begin
                for (int q = 0; q < vecs[v].bub_len; q++) begin
                    in_valid_i = 1'b0;
                    a_col_i    = {N{8'h5A}};
                    b_row_i    = {N{8'hA5}};
                    start_i    = vecs[v].glitch && (q == 0);
                    tick();
                    start_i = 1'b0;
                    check("bubble_ready", 64'(in_ready_o), 64'(1));
                end
            end
            load_beat(v, k);
            in_valid_i = 1'b1;
            exp_accept = 1;
            tick();
            in_valid_i = 1'b0;
        end
        a_col_i = {N{8'h77}};
        b_row_i = {N{8'h88}};
        check("flush_ready", 64'(in_ready_o), 64'(0));
        for (int c = 1; c <= 2 * N; c++) begin
            check($sformatf("done_at_T+%0d", c), 64'(done_o), 64'(c == 2 * N));
            check("flush_busy", 64'(busy_o), 64'(1));
            if (c == 2 * N) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        check($sformatf("C[%0d][%0d]_v%0d", i, j, v),
                              64'(acc[i][j]), 64'(vecs[v].c[i*N+j]));
                check("stale_a", 64'(a_o), 64'(0));
                check("stale_b", 64'(b_o), 64'(0));
            end else begin
                in_valid_i = 1'b1;       // ignored outside FEED
                start_i    = vecs[v].glitch && (c == 3);
                tick();
                start_i    = 1'b0;
                in_valid_i = 1'b0;
            end
        end
        tick();
        check("idle_busy", 64'(busy_o), 64'(0));
        check("idle_done", 64'(done_o), 64'(0));
        tick();
        check("clr_count", 64'(clr_seen), 64'(1));
        check("done_count", 64'(done_seen), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: identity x sequence, same with a 2-cycle bubble, all-0xFF,
        // and an anti-diagonal permutation with a bubble and start glitches.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                vecs[0].a[i*N+k] = (i == k) ? 8'd1 : 8'd0;
                vecs[0].b[i*N+k] = 8'(i * 4 + k + 1);
                vecs[0].c[i*N+k] = 32'(i * 4 + k + 1);
                vecs[2].a[i*N+k] = 8'hFF;
                vecs[2].b[i*N+k] = 8'hFF;
                vecs[2].c[i*N+k] = 32'h0003_F804;
                vecs[3].a[i*N+k] = (k == N - 1 - i) ? 8'd1 : 8'd0;
                vecs[3].b[i*N+k] = 8'(i * 4 + k + 1);
                vecs[3].c[i*N+k] = 32'((N - 1 - i) * 4 + k + 1);
            end
        end
        vecs[1] = vecs[0];
        vecs[0].bub_after = -1; vecs[0].bub_len = 0; vecs[0].glitch = 0;
        vecs[1].bub_after = 1;  vecs[1].bub_len = 2; vecs[1].glitch = 0;
        vecs[2].bub_after = -1; vecs[2].bub_len = 0; vecs[2].glitch = 0;
        vecs[3].bub_after = 0;  vecs[3].bub_len = 1; vecs[3].glitch = 1;

        clear_hist();
        reset_n    = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        a_col_i    = '0;
        b_row_i    = '0;

        // Reset held with random inputs: every output stays at zero.
        for (int r = 0; r < 4; r++) begin
            start_i    = 1'($urandom);
            in_valid_i = 1'($urandom);
            a_col_i    = $urandom;
            b_row_i    = $urandom;
            tick();
            check("rst_ready", 64'(in_ready_o), 64'(0));
            check("rst_clr", 64'(clr_o), 64'(0));
            check("rst_busy", 64'(busy_o), 64'(0));
            check("rst_done", 64'(done_o), 64'(0));
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        reset_n    = 1'b1;
        for (int r = 0; r < 3; r++) tick();
        check("idle_busy0", 64'(busy_o), 64'(0));

        for (int v = 0; v < 4; v++) begin
            $display("product %0d bubble_after %0d len %0d glitch %0d",
                     v, vecs[v].bub_after, vecs[v].bub_len, vecs[v].glitch);
            run_product(v);
        end

        // Reset after the 2nd accept: product abandoned, no done, then a clean rerun.
        clr_seen  = 0;
        done_seen = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            load_beat(0, k);
            in_valid_i = 1'b1;
            exp_accept = 1;
            tick();
        end
        in_valid_i = 1'b0;
        reset_n = 1'b0;
        #1;
        clear_hist();
        check("abort_busy", 64'(busy_o), 64'(0));
        check("abort_ready", 64'(in_ready_o), 64'(0));
        check("abort_a", 64'(a_o), 64'(0));
        check("abort_b", 64'(b_o), 64'(0));
        for (int r = 0; r < 3; r++) tick();
        reset_n = 1'b1;
        for (int r = 0; r < 10; r++) tick();
        check("abort_no_done", 64'(done_seen), 64'(0));
        check("abort_busy_idle", 64'(busy_o), 64'(0));
        $display("product after abort");
        run_product(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
